// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. Data accesses normally win; a small run counter lets
// fetch through after MAX_DATA_RUN consecutive data grants. One access is
// outstanding at a time, and read data returns to whichever side owns it.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    // fetch requester
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    // data requester
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    // memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    // stall requests to hazard control
    output logic                  stall_if,
    output logic                  stall_d
);

    localparam int         BE_W    = DATA_W / 8;
    localparam logic [2:0] MAX_RUN = 3'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_d_q;     // 1 = data side owns the access
    logic [2:0]          run_cnt_q;     // consecutive data grants while fetch waits
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;
    logic                if_valid_q;
    logic                d_valid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    // A requester whose completion pulse is showing is about to drop its
    // request, so it must not be re-arbitrated in that cycle.
    logic if_req_m;
    logic d_req_m;
    logic pick_d;
    logic [2:0] run_cnt_inc;

    assign if_req_m    = if_req & ~if_valid_q;
    assign d_req_m     = d_req & ~d_valid_q;
    assign pick_d      = d_req_m & ~(if_req_m & (run_cnt_q == MAX_RUN));
    assign run_cnt_inc = (run_cnt_q >= MAX_RUN) ? MAX_RUN : run_cnt_q + 3'd1;

    // Arbitration FSM with registered memory-port fields and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            run_cnt_q   <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req_m || d_req_m) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        owner_d_q <= pick_d;
                        if (pick_d) begin
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_be_q    <= d_be;
                            run_cnt_q   <= if_req ? run_cnt_inc : 3'd0;
                        end else begin
                            // fetches are always full-word reads
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= if_addr;
                            mem_be_q   <= '1;
                            run_cnt_q  <= 3'd0;
                        end
                    end else if (!if_req) begin
                        run_cnt_q <= 3'd0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            // stores complete on acceptance, no response phase
                            d_valid_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (mem_rvalid) begin
                        if (owner_d_q) begin
                            d_rdata_q <= mem_rdata;
                            d_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_d   = d_req & ~d_valid_q;

endmodule
